// File: rtl/ysyx_23060201_mem_arb.sv
// Two-requester (IFU/LSU) memory arbiter, one transaction outstanding.
// Round-robin grant, registered response pulse, per-transaction timeout.
module ysyx_23060201_mem_arb #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ifu_req_valid,
   output logic                    ifu_req_ready,
   input  logic [ADDR_WIDTH-1:0]   ifu_addr,
   output logic                    ifu_rsp_valid,
   output logic [DATA_WIDTH-1:0]   ifu_rdata,
   output logic                    ifu_rsp_err,
   input  logic                    lsu_req_valid,
   output logic                    lsu_req_ready,
   input  logic [ADDR_WIDTH-1:0]   lsu_addr,
   input  logic                    lsu_wen,
   input  logic [DATA_WIDTH-1:0]   lsu_wdata,
   input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
   output logic                    lsu_rsp_valid,
   output logic [DATA_WIDTH-1:0]   lsu_rdata,
   output logic                    lsu_rsp_err,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic                    mem_wen,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wmask,
   input  logic                    mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_rsp_err
);

   localparam int MW = DATA_WIDTH / 8;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic                  last_lsu_q;
   logic [CW-1:0]         cnt_q;
   logic                  own_lsu_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  wen_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [MW-1:0]         wmask_q;
   logic                  ifu_vld_q;
   logic [DATA_WIDTH-1:0] ifu_rdata_q;
   logic                  ifu_err_q;
   logic                  lsu_vld_q;
   logic [DATA_WIDTH-1:0] lsu_rdata_q;
   logic                  lsu_err_q;

   logic sel_lsu;
   logic accept;
   logic mem_done;
   logic tmo;

   // Prefer whichever side was not granted last; a lone requester always wins.
   assign sel_lsu = lsu_req_valid ? (!ifu_req_valid || !last_lsu_q)
                                  : (!ifu_req_valid && !last_lsu_q);

   assign accept   = (state_q == S_IDLE) &&
                     (sel_lsu ? lsu_req_valid : ifu_req_valid);
   assign mem_done = (state_q == S_WAIT) && mem_rsp_valid;
   assign tmo      = (state_q != S_IDLE) && !mem_done &&
                     (cnt_q == CW'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; a real response wins over a same-cycle timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = S_REQ;
         S_REQ: begin
            if (tmo)                state_d = S_IDLE;
            else if (mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: if (mem_done || tmo) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake and memory-side outputs.
   always_comb begin
      ifu_req_ready = (state_q == S_IDLE) && !sel_lsu;
      lsu_req_ready = (state_q == S_IDLE) && sel_lsu;
      mem_req_valid = (state_q == S_REQ);
      mem_addr      = addr_q;
      mem_wen       = wen_q;
      mem_wdata     = wdata_q;
      mem_wmask     = wmask_q;
      ifu_rsp_valid = ifu_vld_q;
      ifu_rdata     = ifu_rdata_q;
      ifu_rsp_err   = ifu_err_q;
      lsu_rsp_valid = lsu_vld_q;
      lsu_rdata     = lsu_rdata_q;
      lsu_rsp_err   = lsu_err_q;
   end

   // Request latch, grant history, timeout counter and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_lsu_q  <= 1'b1;
         cnt_q       <= '0;
         own_lsu_q   <= 1'b0;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         ifu_vld_q   <= 1'b0;
         ifu_rdata_q <= '0;
         ifu_err_q   <= 1'b0;
         lsu_vld_q   <= 1'b0;
         lsu_rdata_q <= '0;
         lsu_err_q   <= 1'b0;
      end else begin
         ifu_vld_q <= 1'b0;
         lsu_vld_q <= 1'b0;
         if (accept) begin
            own_lsu_q  <= sel_lsu;
            last_lsu_q <= sel_lsu;
            addr_q     <= sel_lsu ? lsu_addr : ifu_addr;
            wen_q      <= sel_lsu && lsu_wen;
            wdata_q    <= sel_lsu ? lsu_wdata : '0;
            wmask_q    <= sel_lsu ? lsu_wmask : '0;
            cnt_q      <= '0;
         end else if (state_q != S_IDLE) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (mem_done || tmo) begin
            if (own_lsu_q) begin
               lsu_vld_q   <= 1'b1;
               lsu_rdata_q <= mem_done ? mem_rdata : '0;
               lsu_err_q   <= mem_done ? mem_rsp_err : 1'b1;
            end else begin
               ifu_vld_q   <= 1'b1;
               ifu_rdata_q <= mem_done ? mem_rdata : '0;
               ifu_err_q   <= mem_done ? mem_rsp_err : 1'b1;
            end
         end
      end
   end

endmodule
